// File: rtl/btn_event.sv
// btn_event: debounced button level to press/release/click/double-click/long-press strobes (clk, rst_n, btn in; *_p strobes and held out)
module btn_event #(
  parameter int LONG_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 25000000,
  parameter int CNT_W       = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic dclick_p,
  output logic long_p,
  output logic held
);
  typedef enum logic [2:0] {IDLE, DOWN1, WAIT, DOWN2, LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(GAP_CYCLES - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic btn_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_q     <= 1'b1;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      click_p   <= 1'b0;
      dclick_p  <= 1'b0;
      long_p    <= 1'b0;
      held      <= 1'b0;
    end else begin
      btn_q     <= btn;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      click_p   <= 1'b0;
      dclick_p  <= 1'b0;
      long_p    <= 1'b0;
      case (state)
        IDLE:
          if (btn && !btn_q) begin
            state   <= DOWN1;
            cnt     <= '0;
            press_p <= 1'b1;
            held    <= 1'b1;
          end
        DOWN1:
          if (!btn) begin
            state     <= WAIT;
            cnt       <= '0;
            release_p <= 1'b1;
            held      <= 1'b0;
          end else if (cnt == LONG_T) begin
            state  <= LONG;
            long_p <= 1'b1;
          end else cnt <= cnt + 1'b1;
        WAIT:
          if (btn) begin
            state    <= DOWN2;
            dclick_p <= 1'b1;
            press_p  <= 1'b1;
            held     <= 1'b1;
          end else if (cnt == GAP_T) begin
            state   <= IDLE;
            click_p <= 1'b1;
          end else cnt <= cnt + 1'b1;
        DOWN2, LONG:
          if (!btn) begin
            state     <= IDLE;
            release_p <= 1'b1;
            held      <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
